btb_set_assoc: RTL and testbench
================================

// Module: btb_set_assoc
// PURPOSE
//  Parametrised set-associative branch target buffer for the IF/ID pipeline.
//  - IF stage: combinational lookup returns hit, taken prediction and target.
//  - ID stage: resolved branches update a per-entry saturating counter and target.
//  - Misses allocate into an invalid way first, otherwise the true-LRU way of the set.
// PARAMETERS
//  DATA_WIDTH  32  PC and target width.
//  SETS        4   Number of sets. Power of 2, >=2.
//  WAYS        2   Ways per set. Power of 2, >=2.
//  CNT_WIDTH   2   Saturating predictor counter width. >=2.
// PORTS
//  clk               in   1           Clock, rising edge.
//  rst_n             in   1           Asynchronous reset, active-low.
//  en                in   1           State update enable; 0 freezes all state.
//  flush             in   1           Synchronous invalidate of all entries.
//  lookup_valid      in   1           IF lookup request.
//  lookup_pc         in   DATA_WIDTH  IF PC.
//  pred_hit          out  1           Lookup hit.
//  pred_taken        out  1           Predicted taken (counter MSB).
//  pred_target       out  DATA_WIDTH  Predicted next PC.
//  update_valid      in   1           ID-resolved branch present.
//  update_pc         in   DATA_WIDTH  PC of the resolved branch.
//  update_target     in   DATA_WIDTH  Resolved target address.
//  update_taken      in   1           Actual outcome.
//  update_mispredict in   1           Prediction was wrong.
//                                     Used only by the perf counters.
// BEHAVIOUR
//  - Address split: IDX = $clog2(SETS).
//    - index = pc[2 +: IDX].
//    - tag = pc[DATA_WIDTH-1 : 2+IDX].
//    - pc[1:0] is ignored.
//  - Lookup is combinational, zero latency. Hit = valid && tag match in the indexed set.
//    - Hit: pred_taken = cnt[CNT_WIDTH-1]; pred_target = stored target.
//    - Miss, or lookup_valid=0: pred_hit=0, pred_taken=0, pred_target = lookup_pc+4 (mod 2^DATA_WIDTH).
//  - Reset (rst_n=0, async): all valid=0, counters = weakly-taken (MSB=1, rest 0), targets=0, LRU ages = way index.
//    - Outputs follow the miss rule above.
//  - State changes only on posedge clk with en=1. Priority: flush > update > lookup touch.
//  - flush: all valid cleared next cycle.
//    - LRU and counters are untouched.
//    - A concurrent update or touch is discarded.
//  - Update, on hit in update set:
//    - counter +1 if update_taken, otherwise -1. Saturates at 0 and 2^CNT_WIDTH-1.
//    - target <= update_target.
//    - way becomes MRU.
//  - Update, on miss with update_taken=1: allocate a way.
//    - Victim = lowest-numbered invalid way; if none, the way with age WAYS-1.
//    - Written: valid=1, tag, target, counter = weakly-taken. The way becomes MRU.
//  - Update, on miss with update_taken=0: no allocation, no state change.
//  - LRU: per-way age of $clog2(WAYS) bits per set; ages within a set are always a permutation.
//    - Touch of way w: ways with age < age[w] increment; age[w] <= 0.
//  - Lookup touch: a lookup hit with en=1 touches the hit way.
//    - If the update targets the same set in the same cycle, only the update touch is applied.
//  - Same-cycle lookup and update of the same PC: lookup sees pre-update state. No bypass.
//  - en=0: lookup outputs remain valid; no state changes, including perf counters.
// CONFIGURATION
//  - BTB_PERF_CNT_EN defined: adds outputs perf_lookups, perf_hits, perf_mispredicts (each 32 bits).
//    - Each counts with en=1 and flush=0: lookup_valid, lookup hit, update_valid && update_mispredict.
//    - Counters wrap at 2^32 and reset to 0.
//  - BTB_PERF_CNT_EN undefined: those ports and registers do not exist; behaviour is otherwise identical.
// TESTING
//  1. Reset, then lookup 0x100 -> hit=0, taken=0, target=0x104.
//  2. Update pc=0x100, taken=1, tgt=0x200; next-cycle lookup 0x100 -> hit=1, taken=1, target=0x200.
//  3. Counter saturation (CNT_WIDTH=2), for the 0x100 entry:
//     - 3 taken updates, then 1 not-taken -> taken=1.
//     - 2 more not-taken -> taken=0.
//     - 5 further not-taken, then 1 taken -> taken=0 (counter=1).
//  4. LRU eviction (SETS=4, WAYS=2):
//     - Allocate 0x100 and 0x140 (same set), then lookup-hit 0x100.
//     - Allocate 0x180 -> 0x140 evicted; 0x100 and 0x180 both hit.
//  5. flush=1 with a concurrent update of 0x300 -> all lookups miss next cycle, 0x300 included;
//     then drive rst_n low mid-cycle -> outputs are miss values immediately.
//  6. BTB_PERF_CNT_EN: 10 lookups, 6 hits, 3 mispredicting updates, one cycle with en=0
//     -> counters read 10, 6, 3; the en=0 cycle is not counted.

Source files
------------

// File: rtl/btb_set_assoc.sv
// Set-associative branch target buffer: combinational IF lookup, ID-stage update, true-LRU replacement.
// Define BTB_PERF_CNT_EN to add lookup/hit/mispredict performance counters.
module btb_set_assoc #(
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 4,
    parameter int WAYS       = 2,
    parameter int CNT_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  lookup_valid,
    input  logic [DATA_WIDTH-1:0] lookup_pc,
    output logic                  pred_hit,
    output logic                  pred_taken,
    output logic [DATA_WIDTH-1:0] pred_target,
    input  logic                  update_valid,
    input  logic [DATA_WIDTH-1:0] update_pc,
    input  logic [DATA_WIDTH-1:0] update_target,
    input  logic                  update_taken,
    input  logic                  update_mispredict
`ifdef BTB_PERF_CNT_EN
   ,output logic [31:0]           perf_lookups,
    output logic [31:0]           perf_hits,
    output logic [31:0]           perf_mispredicts
`endif
);
    localparam int IDX = $clog2(SETS);
    localparam int AW  = $clog2(WAYS);
    localparam int TW  = DATA_WIDTH - 2 - IDX;
    localparam logic [CNT_WIDTH-1:0] CNT_WEAK = {1'b1, {(CNT_WIDTH-1){1'b0}}};
    localparam logic [AW-1:0]        AGE_OLD  = AW'(WAYS - 1);

    logic                  valid_q [SETS][WAYS];
    logic                  valid_d [SETS][WAYS];
    logic [TW-1:0]         tag_q   [SETS][WAYS];
    logic [TW-1:0]         tag_d   [SETS][WAYS];
    logic [DATA_WIDTH-1:0] tgt_q   [SETS][WAYS];
    logic [DATA_WIDTH-1:0] tgt_d   [SETS][WAYS];
    logic [CNT_WIDTH-1:0]  cnt_q   [SETS][WAYS];
    logic [CNT_WIDTH-1:0]  cnt_d   [SETS][WAYS];
    logic [AW-1:0]         age_q   [SETS][WAYS];
    logic [AW-1:0]         age_d   [SETS][WAYS];

    logic [IDX-1:0] l_idx, u_idx;
    logic [TW-1:0]  l_tag, u_tag;
    logic           l_hit, u_hit, victim_found, u_touch;
    logic [AW-1:0]  l_way, u_way, victim, u_tw;

    assign l_idx = lookup_pc[2 +: IDX];
    assign u_idx = update_pc[2 +: IDX];
    assign l_tag = lookup_pc[DATA_WIDTH-1:2+IDX];
    assign u_tag = update_pc[DATA_WIDTH-1:2+IDX];

    logic unused_bits;
    assign unused_bits = ^{update_mispredict, lookup_pc[1:0], update_pc[1:0]};

    always_comb begin
        l_hit        = 1'b0;
        l_way        = '0;
        u_hit        = 1'b0;
        u_way        = '0;
        victim       = '0;
        victim_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!l_hit && valid_q[l_idx][w] && tag_q[l_idx][w] == l_tag) begin
                l_hit = 1'b1;
                l_way = AW'(w);
            end
            if (!u_hit && valid_q[u_idx][w] && tag_q[u_idx][w] == u_tag) begin
                u_hit = 1'b1;
                u_way = AW'(w);
            end
            if (!victim_found && !valid_q[u_idx][w]) begin
                victim_found = 1'b1;
                victim       = AW'(w);
            end
        end
        // With every way valid, the oldest way is the one carrying the maximum age.
        if (!victim_found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[u_idx][w] == AGE_OLD) victim = AW'(w);
            end
        end
    end

    assign pred_hit    = lookup_valid && l_hit;
    assign pred_taken  = pred_hit && cnt_q[l_idx][l_way][CNT_WIDTH-1];
    assign pred_target = pred_hit ? tgt_q[l_idx][l_way] : lookup_pc + DATA_WIDTH'(4);

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        age_d   = age_q;
        u_touch = 1'b0;
        u_tw    = '0;
        if (en) begin
            if (flush) begin
                for (int s = 0; s < SETS; s++)
                    for (int w = 0; w < WAYS; w++)
                        valid_d[s][w] = 1'b0;
            end else begin
                if (update_valid && u_hit) begin
                    if (update_taken && cnt_q[u_idx][u_way] != '1)
                        cnt_d[u_idx][u_way] = cnt_q[u_idx][u_way] + 1'b1;
                    else if (!update_taken && cnt_q[u_idx][u_way] != '0)
                        cnt_d[u_idx][u_way] = cnt_q[u_idx][u_way] - 1'b1;
                    tgt_d[u_idx][u_way] = update_target;
                    u_touch = 1'b1;
                    u_tw    = u_way;
                end else if (update_valid && update_taken) begin
                    valid_d[u_idx][victim] = 1'b1;
                    tag_d[u_idx][victim]   = u_tag;
                    tgt_d[u_idx][victim]   = update_target;
                    cnt_d[u_idx][victim]   = CNT_WEAK;
                    u_touch = 1'b1;
                    u_tw    = victim;
                end
                if (u_touch) begin
                    for (int w = 0; w < WAYS; w++)
                        if (age_q[u_idx][w] < age_q[u_idx][u_tw])
                            age_d[u_idx][w] = age_q[u_idx][w] + 1'b1;
                    age_d[u_idx][u_tw] = '0;
                end
                // An update touch in the same set takes precedence over the lookup touch.
                if (pred_hit && !(u_touch && u_idx == l_idx)) begin
                    for (int w = 0; w < WAYS; w++)
                        if (age_q[l_idx][w] < age_q[l_idx][l_way])
                            age_d[l_idx][w] = age_q[l_idx][w] + 1'b1;
                    age_d[l_idx][l_way] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    tag_q[s][w]   <= '0;
                    tgt_q[s][w]   <= '0;
                    cnt_q[s][w]   <= CNT_WEAK;
                    age_q[s][w]   <= AW'(w);
                end
            end
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            age_q   <= age_d;
        end
    end

`ifdef BTB_PERF_CNT_EN
    logic [31:0] perf_lookups_q, perf_lookups_d;
    logic [31:0] perf_hits_q, perf_hits_d;
    logic [31:0] perf_misp_q, perf_misp_d;

    always_comb begin
        perf_lookups_d = perf_lookups_q;
        perf_hits_d    = perf_hits_q;
        perf_misp_d    = perf_misp_q;
        if (en && !flush) begin
            perf_lookups_d = perf_lookups_q + 32'(lookup_valid);
            perf_hits_d    = perf_hits_q + 32'(pred_hit);
            perf_misp_d    = perf_misp_q + 32'(update_valid && update_mispredict);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_lookups_q <= '0;
            perf_hits_q    <= '0;
            perf_misp_q    <= '0;
        end else begin
            perf_lookups_q <= perf_lookups_d;
            perf_hits_q    <= perf_hits_d;
            perf_misp_q    <= perf_misp_d;
        end
    end

    assign perf_lookups     = perf_lookups_q;
    assign perf_hits        = perf_hits_q;
    assign perf_mispredicts = perf_misp_q;
`endif
endmodule

// File: tb/tb_btb_set_assoc.sv
// Self-checking bench for btb_set_assoc: directed literal checks plus randomized traffic
// compared every cycle against a list-based LRU reference model.
module tb_btb_set_assoc;
    localparam int DW    = 32;
    localparam int S     = 4;
    localparam int W     = 2;
    localparam int CW    = 2;
    localparam int IDXB  = $clog2(S);
    localparam int CMAX  = (1 << CW) - 1;
    localparam int CWEAK = 1 << (CW - 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          en = 1'b1, flush = 1'b0, lookup_valid = 1'b0;
    logic          update_valid = 1'b0, update_taken = 1'b0, update_mispredict = 1'b0;
    logic [DW-1:0] lookup_pc = '0, update_pc = '0, update_target = '0;
    logic          pred_hit, pred_taken;
    logic [DW-1:0] pred_target;
`ifdef BTB_PERF_CNT_EN
    logic [31:0]   perf_lookups, perf_hits, perf_mispredicts;
`endif

    btb_set_assoc #(.DATA_WIDTH(DW), .SETS(S), .WAYS(W), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .update_valid(update_valid), .update_pc(update_pc), .update_target(update_target),
        .update_taken(update_taken), .update_mispredict(update_mispredict)
`ifdef BTB_PERF_CNT_EN
       ,.perf_lookups(perf_lookups), .perf_hits(perf_hits), .perf_mispredicts(perf_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: per-set recency list, m_order[s][0] is most recently used.
    bit            m_valid [S][W];
    logic [DW-1:0] m_tag   [S][W];
    logic [DW-1:0] m_tgt   [S][W];
    int            m_cnt   [S][W];
    int            m_order [S][W];
    logic [31:0]   m_lookups, m_hits, m_misp;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic int set_of(input logic [DW-1:0] pc);
        return int'((pc >> 2) % S);
    endfunction

    function automatic logic [DW-1:0] tag_of(input logic [DW-1:0] pc);
        return pc >> (2 + IDXB);
    endfunction

    function automatic int find_way(input logic [DW-1:0] pc);
        int s;
        s = set_of(pc);
        for (int w = 0; w < W; w++)
            if (m_valid[s][w] && m_tag[s][w] == tag_of(pc)) return w;
        return -1;
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < S; s++) begin
            for (int w = 0; w < W; w++) begin
                m_valid[s][w] = 1'b0;
                m_tag[s][w]   = '0;
                m_tgt[s][w]   = '0;
                m_cnt[s][w]   = CWEAK;
                m_order[s][w] = w;
            end
        end
        m_lookups = '0;
        m_hits    = '0;
        m_misp    = '0;
    endfunction

    function automatic void touch(input int s, input int w);
        int p;
        p = 0;
        for (int i = 0; i < W; i++) if (m_order[s][i] == w) p = i;
        for (int i = p; i > 0; i--) m_order[s][i] = m_order[s][i-1];
        m_order[s][0] = w;
    endfunction

    function automatic void model_step();
        int  ls, lw, us, uw, vw;
        bit  utouch;
        if (!en) return;
        lw = lookup_valid ? find_way(lookup_pc) : -1;
        if (flush) begin
            for (int s = 0; s < S; s++)
                for (int w = 0; w < W; w++) m_valid[s][w] = 1'b0;
            return;
        end
        if (lookup_valid) m_lookups++;
        if (lw >= 0) m_hits++;
        if (update_valid && update_mispredict) m_misp++;
        ls = set_of(lookup_pc);
        us = set_of(update_pc);
        uw = find_way(update_pc);
        utouch = 1'b0;
        if (update_valid) begin
            if (uw >= 0) begin
                if (update_taken) m_cnt[us][uw] = (m_cnt[us][uw] >= CMAX) ? CMAX : m_cnt[us][uw] + 1;
                else              m_cnt[us][uw] = (m_cnt[us][uw] <= 0) ? 0 : m_cnt[us][uw] - 1;
                m_tgt[us][uw] = update_target;
                touch(us, uw);
                utouch = 1'b1;
            end else if (update_taken) begin
                vw = -1;
                for (int w = W - 1; w >= 0; w--) if (!m_valid[us][w]) vw = w;
                if (vw < 0) vw = m_order[us][W-1];
                m_valid[us][vw] = 1'b1;
                m_tag[us][vw]   = tag_of(update_pc);
                m_tgt[us][vw]   = update_target;
                m_cnt[us][vw]   = CWEAK;
                touch(us, vw);
                utouch = 1'b1;
            end
        end
        if (lw >= 0 && !(utouch && us == ls)) touch(ls, lw);
    endfunction

    always @(posedge clk) if (rst_n === 1'b1) model_step();

    always @(negedge clk) begin
        int            w;
        logic          eh, et;
        logic [DW-1:0] etg;
        if (chk_on) begin
            w   = lookup_valid ? find_way(lookup_pc) : -1;
            eh  = (w >= 0);
            et  = (w >= 0) ? (m_cnt[set_of(lookup_pc)][w] >= CWEAK) : 1'b0;
            etg = (w >= 0) ? m_tgt[set_of(lookup_pc)][w] : lookup_pc + 32'd4;
            chk("cmp_hit", pred_hit, eh);
            chk("cmp_taken", pred_taken, et);
            chk("cmp_target", pred_target, etg);
`ifdef BTB_PERF_CNT_EN
            chk("cmp_perf_lookups", perf_lookups, m_lookups);
            chk("cmp_perf_hits", perf_hits, m_hits);
            chk("cmp_perf_misp", perf_mispredicts, m_misp);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic upd(input logic [DW-1:0] pc, input logic [DW-1:0] tg, input logic tk);
        update_valid = 1'b1; update_pc = pc; update_target = tg; update_taken = tk;
        tick();
        update_valid = 1'b0;
    endtask

    task automatic look(input logic [DW-1:0] pc, input logic eh, input logic et,
                        input logic [DW-1:0] etg, input string nm);
        lookup_valid = 1'b1; lookup_pc = pc;
        #1;
        chk({nm, "_hit"}, pred_hit, eh);
        chk({nm, "_taken"}, pred_taken, et);
        chk({nm, "_target"}, pred_target, etg);
        tick();
        lookup_valid = 1'b0;
    endtask

    function automatic logic [DW-1:0] rand_pc();
        logic [DW-1:0] pc;
        pc = DW'(($urandom_range(0, 5) << 4) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) pc = pc | 32'h8000_0000;
        return pc;
    endfunction

    initial begin
        #1;
        do_reset();
        chk_on = 1'b1;

        look(32'h100, 1'b0, 1'b0, 32'h104, "t1_reset_miss");
        look(32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0000_0002, "t1_wrap");

        upd(32'h100, 32'h200, 1'b1);
        look(32'h100, 1'b1, 1'b1, 32'h200, "t2_alloc");

        repeat (3) upd(32'h100, 32'h200, 1'b1);
        upd(32'h100, 32'h200, 1'b0);
        look(32'h100, 1'b1, 1'b1, 32'h200, "t3_sat_hi");
        repeat (2) upd(32'h100, 32'h200, 1'b0);
        look(32'h100, 1'b1, 1'b0, 32'h200, "t3_nt");
        repeat (5) upd(32'h100, 32'h200, 1'b0);
        upd(32'h100, 32'h200, 1'b1);
        look(32'h100, 1'b1, 1'b0, 32'h200, "t3_sat_lo");

        do_reset();
        upd(32'h100, 32'h1100, 1'b1);
        upd(32'h140, 32'h1140, 1'b1);
        look(32'h100, 1'b1, 1'b1, 32'h1100, "t4_touch");
        upd(32'h180, 32'h1180, 1'b1);
        look(32'h140, 1'b0, 1'b0, 32'h144, "t4_evicted");
        look(32'h100, 1'b1, 1'b1, 32'h1100, "t4_keep");
        look(32'h180, 1'b1, 1'b1, 32'h1180, "t4_new");

        flush = 1'b1;
        upd(32'h300, 32'h3300, 1'b1);
        flush = 1'b0;
        look(32'h100, 1'b0, 1'b0, 32'h104, "t5_flush_a");
        look(32'h180, 1'b0, 1'b0, 32'h184, "t5_flush_b");
        look(32'h300, 1'b0, 1'b0, 32'h304, "t5_flush_upd");
        upd(32'h100, 32'h1100, 1'b1);
        lookup_valid = 1'b1; lookup_pc = 32'h100;
        #1;
        chk("t5_pre_rst_hit", pred_hit, 1'b1);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t5_rst_hit", pred_hit, 1'b0);
        chk("t5_rst_taken", pred_taken, 1'b0);
        chk("t5_rst_target", pred_target, 32'h104);
        repeat (2) tick();
        rst_n = 1'b1;
        lookup_valid = 1'b0;

`ifdef BTB_PERF_CNT_EN
        do_reset();
        chk("t6_perf_rst", perf_lookups, 32'd0);
        update_mispredict = 1'b1;
        upd(32'h100, 32'h900, 1'b1);
        update_mispredict = 1'b0;
        for (int i = 0; i < 10; i++) begin
            lookup_valid = 1'b1;
            lookup_pc = (i < 6) ? 32'h100 : 32'h500;
            if (i == 2 || i == 7) begin
                update_valid = 1'b1; update_pc = 32'h100; update_taken = 1'b1;
                update_target = 32'h900; update_mispredict = 1'b1;
            end
            tick();
            update_valid = 1'b0; update_mispredict = 1'b0;
        end
        en = 1'b0; lookup_valid = 1'b1; lookup_pc = 32'h100;
        update_valid = 1'b1; update_mispredict = 1'b1;
        tick();
        en = 1'b1; lookup_valid = 1'b0; update_valid = 1'b0; update_mispredict = 1'b0;
        chk("t6_lookups", perf_lookups, 32'd10);
        chk("t6_hits", perf_hits, 32'd6);
        chk("t6_misp", perf_mispredicts, 32'd3);
`endif

        do_reset();
        for (int c = 0; c < 2000; c++) begin
            en                = ($urandom_range(0, 9) != 0);
            flush             = ($urandom_range(0, 31) == 0);
            lookup_valid      = ($urandom_range(0, 4) != 0);
            lookup_pc         = rand_pc();
            update_valid      = ($urandom_range(0, 1) != 0);
            update_pc         = ($urandom_range(0, 3) == 0) ? lookup_pc : rand_pc();
            update_target     = $urandom();
            update_taken      = ($urandom_range(0, 9) < 6);
            update_mispredict = ($urandom_range(0, 1) != 0);
            tick();
        end
        en = 1'b1; flush = 1'b0; lookup_valid = 1'b0; update_valid = 1'b0;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
